// File: rtl/break_sequencer.sv
// Debug run-control sequencer: programs breakpoints, detects halts, issues continue pulses.
// Optional single-step support (counter, step_pend, STEP_RUN) is built when BREAK_SEQ_STEP_EN is defined.
module break_sequencer #(
    parameter int STEP_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [31:0]       cmd_data,
    input  logic              stop_clk,
    output logic              break_continue,
    output logic [31:0]       inst_break,
    output logic [31:0]       data_break,
    output logic              inst_break_pc_en,
    output logic              inst_break_en,
    output logic              data_break_rd_en,
    output logic              data_break_wr_en,
    output logic              force_stop,
    output logic              halted,
    output logic [CNT_W-1:0]  halt_count
);

    localparam logic [2:0] OP_SET_IBRK = 3'd1;
    localparam logic [2:0] OP_SET_DBRK = 3'd2;
    localparam logic [2:0] OP_SET_EN   = 3'd3;
    localparam logic [2:0] OP_CONTINUE = 3'd4;
    localparam logic [2:0] OP_STEP     = 3'd5;
    localparam logic [2:0] OP_HALT     = 3'd6;
    localparam logic [2:0] OP_CLR      = 3'd7;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_HALTED   = 3'd1,
        S_CONT     = 3'd2,
        S_WAIT_RUN = 3'd3,
        S_STEP_RUN = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             fire;
    logic             op_cont;
    logic             op_halt;
    logic             op_clr;
    logic             halt_entry;
    logic             force_nxt;
    logic [CNT_W-1:0] count_nxt;

    assign cmd_ready = (state == S_RUN) || (state == S_HALTED) || (state == S_STEP_RUN);
    assign fire      = cmd_valid && cmd_ready;
    assign op_halt   = fire && (cmd_op == OP_HALT);
    assign op_clr    = fire && (cmd_op == OP_CLR);

`ifdef BREAK_SEQ_STEP_EN
    logic              op_step;
    logic              step_pend;
    logic [STEP_W-1:0] step_cnt;
    logic              step_done;

    assign op_cont   = fire && (cmd_op == OP_CONTINUE);
    assign op_step   = fire && (cmd_op == OP_STEP);
    // Counter only advances on cycles the core actually ran, so a breakpoint always beats expiry.
    assign step_done = (state == S_STEP_RUN) && !stop_clk && (step_cnt <= STEP_W'(1));
`else
    // Without step support, STEP is treated exactly like CONTINUE.
    assign op_cont   = fire && ((cmd_op == OP_CONTINUE) || (cmd_op == OP_STEP));
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (stop_clk || op_halt) state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (op_cont) state_nxt = S_CONT;
`ifdef BREAK_SEQ_STEP_EN
                else if (op_step) state_nxt = S_CONT;
`endif
            end
            S_CONT: begin
                state_nxt = S_WAIT_RUN;
            end
            S_WAIT_RUN: begin
                if (stop_clk) state_nxt = S_HALTED;
`ifdef BREAK_SEQ_STEP_EN
                else if (step_pend) state_nxt = S_STEP_RUN;
`endif
                else state_nxt = S_RUN;
            end
`ifdef BREAK_SEQ_STEP_EN
            S_STEP_RUN: begin
                if (stop_clk || op_halt || step_done) state_nxt = S_HALTED;
            end
`endif
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        force_nxt = force_stop;
        if (state_nxt == S_CONT) begin
            force_nxt = 1'b0;
        end else if (((state == S_RUN) || (state == S_STEP_RUN)) && op_halt) begin
            force_nxt = 1'b1;
        end
`ifdef BREAK_SEQ_STEP_EN
        else if (step_done) begin
            force_nxt = 1'b1;
        end
`endif
        halt_entry = (state_nxt == S_HALTED) && (state != S_HALTED);
        count_nxt  = halt_count;
        if (op_clr) begin
            count_nxt = '0;
        end else if (halt_entry && (halt_count != '1)) begin
            count_nxt = halt_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halted         <= 1'b0;
            break_continue <= 1'b0;
            force_stop     <= 1'b0;
            halt_count     <= '0;
        end else begin
            halted         <= (state_nxt == S_HALTED);
            break_continue <= (state_nxt == S_CONT);
            force_stop     <= force_nxt;
            halt_count     <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_break       <= '0;
            data_break       <= '0;
            inst_break_pc_en <= 1'b0;
            inst_break_en    <= 1'b0;
            data_break_rd_en <= 1'b0;
            data_break_wr_en <= 1'b0;
        end else if (fire) begin
            case (cmd_op)
                OP_SET_IBRK: inst_break <= cmd_data;
                OP_SET_DBRK: data_break <= cmd_data;
                OP_SET_EN: begin
                    {data_break_wr_en, data_break_rd_en, inst_break_en, inst_break_pc_en} <= cmd_data[3:0];
                end
                OP_CLR: begin
                    inst_break_pc_en <= 1'b0;
                    inst_break_en    <= 1'b0;
                    data_break_rd_en <= 1'b0;
                    data_break_wr_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef BREAK_SEQ_STEP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_pend <= 1'b0;
            step_cnt  <= '0;
        end else begin
            case (state)
                S_HALTED: begin
                    if (op_step) begin
                        step_pend <= 1'b1;
                        step_cnt  <= (cmd_data[STEP_W-1:0] == '0) ? STEP_W'(1) : cmd_data[STEP_W-1:0];
                    end
                end
                S_WAIT_RUN: begin
                    step_pend <= 1'b0;
                    if (stop_clk) step_cnt <= '0;
                end
                S_STEP_RUN: begin
                    if (stop_clk || op_halt) step_cnt <= '0;
                    else step_cnt <= step_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
`endif

endmodule
